// File: rtl/main_data_sequencer_2ch.sv
// Steps the main-data parser through the granule/channel slots of one MP3 frame,
// tracking each slot's bit offset and discarding bits the parser left unread.
module main_data_sequencer_2ch (
  input  logic        clk,
  input  logic        rst,
  input  logic        si_we,
  input  logic        si_gr,
  input  logic        si_ch,
  input  logic [11:0] si_part2_3_length,
  input  logic        stereo,
  input  logic        frame_go,
  input  logic        parser_done,
  input  logic [11:0] parser_bits_used,
  input  logic        fifo_iv,
  output logic        par_start,
  output logic        sel_gr,
  output logic        sel_ch,
  output logic [13:0] bit_offset,
  output logic        skip_rd,
  output logic        busy,
  output logic        frame_done,
  output logic        err_missing,
  output logic        err_overrun
);

  // Handshake: par_start is a one-cycle request, and the parser answers with a
  // one-cycle parser_done; only a parser_done seen in S_WAIT is acted on.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_SKIP, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] len_q [4];
  logic [3:0]  loaded;
  logic [1:0]  slot;
  logic        stereo_q;
  logic [11:0] skip_cnt;

  logic [3:0]  required;
  logic        go_ok;
  logic [11:0] cur_len;
  logic        last_slot;
  logic [1:0]  slot_nxt;

  // Slot index is {gr,ch}; mono only visits index 0 and 2.
  assign required  = stereo ? 4'b1111 : 4'b0101;
  assign go_ok     = frame_go && ((loaded & required) == required);
  assign cur_len   = len_q[slot];
  assign last_slot = stereo_q ? (slot == 2'd3) : (slot == 2'd2);
  assign slot_nxt  = stereo_q ? slot + 2'd1 : 2'd2;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_ok) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (parser_done)
                 state_nxt = (parser_bits_used < cur_len) ? S_SKIP : S_NEXT;
      S_SKIP:  if (fifo_iv && skip_cnt == 12'd1) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_slot ? S_DONE : S_START;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign par_start  = (state == S_START);
  assign skip_rd    = (state == S_SKIP) && fifo_iv;
  assign busy       = (state == S_START) || (state == S_WAIT) ||
                      (state == S_SKIP)  || (state == S_NEXT);
  assign frame_done = (state == S_DONE);
  assign sel_gr     = slot[1];
  assign sel_ch     = slot[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      loaded      <= 4'b0000;
      slot        <= 2'd0;
      stereo_q    <= 1'b0;
      skip_cnt    <= 12'd0;
      bit_offset  <= 14'd0;
      err_missing <= 1'b0;
      err_overrun <= 1'b0;
      for (int i = 0; i < 4; i++) len_q[i] <= 12'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (go_ok) begin
            err_missing <= 1'b0;
            err_overrun <= 1'b0;
            bit_offset  <= 14'd0;
            stereo_q    <= stereo;
            slot        <= 2'd0;
          end else begin
            if (frame_go) err_missing <= 1'b1;
            if (si_we) begin
              len_q[{si_gr, si_ch}]  <= si_part2_3_length;
              loaded[{si_gr, si_ch}] <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (parser_done) begin
            if (parser_bits_used < cur_len)
              skip_cnt <= cur_len - parser_bits_used;
            else if (parser_bits_used > cur_len)
              err_overrun <= 1'b1;
          end
        end
        S_SKIP: begin
          if (fifo_iv) skip_cnt <= skip_cnt - 12'd1;
        end
        S_NEXT: begin
          // Four 12-bit lengths sum to at most 16380, so 14 bits never wrap.
          bit_offset <= bit_offset + {2'b00, cur_len};
          if (!last_slot) slot <= slot_nxt;
        end
        S_DONE: loaded <= 4'b0000;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_data_sequencer_2ch.sv
// Bench for main_data_sequencer_2ch: frame-level reference model (slot order,
// cumulative offsets, total discarded bits) checked by a per-cycle monitor.
module tb_main_data_sequencer_2ch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        si_we = 1'b0;
  logic        si_gr = 1'b0;
  logic        si_ch = 1'b0;
  logic [11:0] si_part2_3_length = 12'd0;
  logic        stereo = 1'b0;
  logic        frame_go = 1'b0;
  logic        parser_done = 1'b0;
  logic [11:0] parser_bits_used = 12'd0;
  logic        fifo_iv = 1'b0;
  logic        par_start, sel_gr, sel_ch, skip_rd, busy, frame_done;
  logic        err_missing, err_overrun;
  logic [13:0] bit_offset;

  main_data_sequencer_2ch dut (
    .clk(clk), .rst(rst), .si_we(si_we), .si_gr(si_gr), .si_ch(si_ch),
    .si_part2_3_length(si_part2_3_length), .stereo(stereo), .frame_go(frame_go),
    .parser_done(parser_done), .parser_bits_used(parser_bits_used), .fifo_iv(fifo_iv),
    .par_start(par_start), .sel_gr(sel_gr), .sel_ch(sel_ch), .bit_offset(bit_offset),
    .skip_rd(skip_rd), .busy(busy), .frame_done(frame_done),
    .err_missing(err_missing), .err_overrun(err_overrun)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          skip_seen = 0;
  int          done_seen = 0;
  int          mark_cyc = 0;
  bit          mark_valid = 1'b0;
  int          fifo_mode = 0;     // 0 always valid, 1 random, 2 driven from fifo_manual
  logic        fifo_manual = 1'b0;
  logic [15:0] exp_q[$];          // {gr, ch, bit_offset} expected at each par_start
  logic [13:0] obs_off[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (fifo_mode == 0)      fifo_iv = 1'b1;
    else if (fifo_mode == 1) fifo_iv = 1'($urandom_range(0, 1));
    else                     fifo_iv = fifo_manual;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      mark_valid = 1'b0;
    end else begin
      if (par_start) begin
        check("par_start_busy", busy, 1);
        if (exp_q.size() == 0) begin
          check("par_start_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("slot_sel", {sel_gr, sel_ch}, e[15:14]);
          check("slot_offset", bit_offset, e[13:0]);
        end
        obs_off.push_back(bit_offset);
        if (mark_valid) check("restart_latency", cyc - mark_cyc, 2);
        mark_valid = 1'b0;
      end
      if (frame_done) begin
        done_seen++;
        check("done_busy", busy, 0);
        if (mark_valid) check("done_latency", cyc - mark_cyc, 2);
        mark_valid = 1'b0;
      end
      if (parser_done && busy) begin
        mark_cyc   = cyc;
        mark_valid = 1'b1;
      end
      if (skip_rd) begin
        skip_seen++;
        check("skip_gated", fifo_iv, 1);
        check("skip_busy", busy, 1);
        mark_cyc   = cyc;
        mark_valid = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [11:0] len);
    si_we = 1'b1;
    si_gr = 1'(idx >> 1);
    si_ch = 1'(idx);
    si_part2_3_length = len;
    tick();
    si_we = 1'b0;
  endtask

  task automatic wait_par(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (par_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("par_start_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {par_start, sel_gr, sel_ch, bit_offset, skip_rd, busy,
                 frame_done, err_missing, err_overrun}, 0);
  endtask

  // Loads all four slots, runs one frame, and checks frame-level results
  // against the reference computed from lengths and bits used.
  task automatic run_frame(input bit st, input logic [11:0] lens [4],
                           input logic [11:0] used [4], input bit pat, input bit noise);
    int          req[$];
    logic [13:0] off;
    int          exp_skip;
    bit          exp_ovr;
    bit          ok;
    bit          found;
    logic        pattern [7];
    pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    off = 14'd0;
    exp_skip = 0;
    exp_ovr = 1'b0;
    if (noise) load(0, 12'($urandom));
    for (int i = 0; i < 4; i++) load(i, lens[i]);
    if (st) req = '{0, 1, 2, 3};
    else    req = '{0, 2};
    foreach (req[k]) begin
      exp_q.push_back({2'(req[k]), off});
      off += {2'b00, lens[req[k]]};
      if (used[req[k]] < lens[req[k]]) exp_skip += int'(lens[req[k]]) - int'(used[req[k]]);
      if (used[req[k]] > lens[req[k]]) exp_ovr = 1'b1;
    end
    skip_seen = 0;
    done_seen = 0;
    obs_off.delete();

    stereo = st;
    frame_go = 1'b1;
    if (noise) begin
      si_we = 1'b1; si_gr = 1'b0; si_ch = 1'b0;
      si_part2_3_length = 12'($urandom);
    end
    tick();
    frame_go = 1'b0;
    si_we = 1'b0;
    check("go_par_start", par_start, 1);
    check("go_busy", busy, 1);
    check("go_err_clear", {err_missing, err_overrun}, 0);

    for (int k = 0; k < req.size(); k++) begin
      if (k > 0) begin
        wait_par(ok);
        if (!ok) break;
      end
      tick();
      repeat ($urandom_range(0, 3)) tick();
      if (noise && k == 0) begin
        frame_go = 1'b1;
        si_we = 1'b1; si_gr = 1'b1; si_ch = 1'b0;
        si_part2_3_length = 12'($urandom);
      end
      parser_done = 1'b1;
      parser_bits_used = used[req[k]];
      tick();
      parser_done = 1'b0;
      frame_go = 1'b0;
      si_we = 1'b0;
      if (pat && k == 0) begin
        for (int p = 0; p < 7; p++) begin
          fifo_manual = pattern[p];
          tick();
        end
        fifo_manual = 1'b0;
      end
    end

    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (frame_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("frame_done_seen", found, 1);
    tick();
    check("frame_skips", skip_seen, exp_skip);
    check("frame_done_count", done_seen, 1);
    check("frame_overrun", err_overrun, exp_ovr);
    check("frame_slots_left", exp_q.size(), 0);
    check("frame_idle_busy", busy, 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] lens [4];
    logic [11:0] used [4];
    int          lit [4];
    bit          ok;

    repeat (3) tick();
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    tick();

    // Stereo, exact parses: offsets 0/100/300/600, no discarded bits.
    lens = '{12'd100, 12'd200, 12'd300, 12'd400};
    used = lens;
    run_frame(1'b1, lens, used, 1'b0, 1'b0);
    lit = '{0, 100, 300, 600};
    check("stereo_starts", obs_off.size(), 4);
    for (int i = 0; i < 4 && i < obs_off.size(); i++) check("stereo_offset_lit", obs_off[i], lit[i]);

    // Mono: only gr0ch0 (50) and gr1ch0 (70).
    lens = '{12'd50, 12'd999, 12'd70, 12'd999};
    used = lens;
    run_frame(1'b0, lens, used, 1'b0, 1'b0);
    check("mono_starts", obs_off.size(), 2);
    if (obs_off.size() == 2) begin
      check("mono_offset0_lit", obs_off[0], 0);
      check("mono_offset1_lit", obs_off[1], 50);
    end

    // Short parse: 20 - 15 = 5 bits discarded under a gappy fifo_iv.
    fifo_mode = 2;
    lens = '{12'd20, 12'd0, 12'd30, 12'd0};
    used = '{12'd15, 12'd0, 12'd30, 12'd0};
    run_frame(1'b0, lens, used, 1'b1, 1'b0);
    check("short_skip_lit", skip_seen, 5);
    fifo_mode = 0;

    // Overrun on the first slot; the sequence still completes.
    lens = '{12'd10, 12'd5, 12'd6, 12'd7};
    used = '{12'd12, 12'd5, 12'd6, 12'd7};
    run_frame(1'b1, lens, used, 1'b0, 1'b0);
    check("overrun_lit", err_overrun, 1);

    // Stereo frame_go with slot (1,1) unloaded.
    load(0, 12'd11); load(1, 12'd12); load(2, 12'd13);
    stereo = 1'b1;
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    check("missing_err", err_missing, 1);
    check("missing_busy", busy, 0);
    check("missing_par_start", par_start, 0);
    tick();
    check("missing_idle", {busy, par_start}, 0);

    // Reset in the middle of a 7-bit discard on slot (0,1).
    fifo_mode = 2;
    fifo_manual = 1'b0;
    lens = '{12'd30, 12'd20, 12'd40, 12'd50};
    for (int i = 0; i < 4; i++) load(i, lens[i]);
    exp_q.push_back({2'd0, 14'd0});
    exp_q.push_back({2'd1, 14'd30});
    stereo = 1'b1;
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    tick();
    parser_done = 1'b1; parser_bits_used = 12'd30;
    tick();
    parser_done = 1'b0;
    wait_par(ok);
    tick();
    parser_done = 1'b1; parser_bits_used = 12'd13;
    tick();
    parser_done = 1'b0;
    tick();
    check("pre_reset_sel_ch", sel_ch, 1);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    fifo_manual = 1'b1;
    tick();
    check_reset_outputs("mid_skip_reset_outputs");
    rst = 1'b0;
    fifo_manual = 1'b0;
    tick();
    check("post_reset_skip", {skip_rd, busy}, 0);
    exp_q.delete();
    fifo_mode = 0;
    stereo = 1'b1;
    frame_go = 1'b1;
    tick();
    frame_go = 1'b0;
    check("post_reset_missing", err_missing, 1);
    check("post_reset_no_start", {busy, par_start}, 0);

    // Randomized frames with ignored frame_go / si_we noise.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        lens[i] = 12'($urandom_range(0, 4095));
        r = $urandom_range(0, 2);
        if (r == 1 && lens[i] > 0)
          used[i] = lens[i] - 12'($urandom_range(1, (lens[i] < 25) ? int'(lens[i]) : 25));
        else if (r == 2 && lens[i] < 12'd4095)
          used[i] = lens[i] + 12'($urandom_range(1, (4095 - int'(lens[i]) < 20) ? 4095 - int'(lens[i]) : 20));
        else
          used[i] = lens[i];
      end
      fifo_mode = $urandom_range(0, 1);
      run_frame(1'($urandom_range(0, 1)), lens, used, 1'b0, 1'b1);
    end
    fifo_mode = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
